// File: rtl/aurora_tx_sched_pkg.sv
// Shared types and constants for the Aurora TX packet scheduler.
package aurora_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    localparam logic [1:0] MODE_HOST = 2'b00;
    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_RR   = 2'b10;
    localparam logic [1:0] MODE_PRIO = 2'b11;

    typedef struct packed {
        logic valid;
        src_t src;
    } pick_t;

    // One IDLE arbitration decision; 'last' is the source granted most recently.
    function automatic pick_t pick_source(input logic [1:0] mode,
                                          input logic       v0,
                                          input logic       v1,
                                          input src_t       last);
        pick_t p;
        p.valid = 1'b0;
        p.src   = SRC0;
        case (mode)
            MODE_HOST: begin
                p.valid = v0;
                p.src   = SRC0;
            end
            MODE_LOOP: begin
                p.valid = v1;
                p.src   = SRC1;
            end
            MODE_RR: begin
                p.valid = v0 | v1;
                if (v0 && v1) p.src = (last == SRC0) ? SRC1 : SRC0;
                else          p.src = v0 ? SRC0 : SRC1;
            end
            default: begin
                p.valid = v0 | v1;
                p.src   = v0 ? SRC0 : SRC1;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sat_pkt_cnt.sv
// Saturating packet counter with a synchronous clear that overrides increment.
module sat_pkt_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aurora_tx_sched.sv
// Two-source AXI-Stream packet scheduler feeding the Aurora TX user interface.
module aurora_tx_sched
    import aurora_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,

    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    input  logic                  channel_up,
    input  logic [1:0]            ctrl_mode,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic                  busy
);

    state_t state, state_nxt;
    src_t   last_grant, last_grant_nxt;
    pick_t  pick;
    logic   end0, end1;

    assign pick = pick_source(ctrl_mode, s0_axis_tvalid, s1_axis_tvalid, last_grant);
    assign end0 = (state == GRANT0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
    assign end1 = (state == GRANT1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state      <= IDLE;
            last_grant <= SRC1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (channel_up && pick.valid) begin
                    state_nxt      = (pick.src == SRC0) ? GRANT0 : GRANT1;
                    last_grant_nxt = pick.src;
                end
            end
            GRANT0:  if (end0) state_nxt = IDLE;
            GRANT1:  if (end1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The grant register steers a pure mux: data passes through with no added latency.
    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            GRANT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
            end
            GRANT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    sat_pkt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .clr   (cnt_clr),
        .inc   (end0),
        .cnt   (pkt_cnt0)
    );

    sat_pkt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .clr   (cnt_clr),
        .inc   (end1),
        .cnt   (pkt_cnt1)
    );

endmodule

// File: doc/aurora_tx_sched.md
AURORA_TX_SCHED -- requirements
Module: aurora_tx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Stream tdata width on all ports.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each per-source packet counter.
REQ-003 SHALL have port m_axis_aclk  in  1  sole clock (Aurora user_clk domain); single clock domain.
REQ-004 SHALL have port m_axis_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports s0_axis_tvalid/tdata/tlast  in  1/DATA_WIDTH/1  host source (pre path).
REQ-006 SHALL have port s0_axis_tready  out  1  host source ready.
REQ-007 SHALL have ports s1_axis_tvalid/tdata/tlast  in  1/DATA_WIDTH/1  loopback source (loop FIFO).
REQ-008 SHALL have port s1_axis_tready  out  1  loopback source ready.
REQ-009 SHALL have ports m_axis_tvalid/tdata/tlast  out  1/DATA_WIDTH/1  to Aurora TX.
REQ-010 SHALL have port m_axis_tready  in  1  Aurora TX ready.
REQ-011 SHALL have port channel_up  in  1  Aurora channel status, synchronous to m_axis_aclk.
REQ-012 SHALL have port ctrl_mode  in  2  00 host only, 01 loopback only, 10 round-robin, 11 fixed priority host.
REQ-013 SHALL have port cnt_clr  in  1  single-cycle clear of both packet counters.
REQ-014 SHALL have ports pkt_cnt0/pkt_cnt1  out  CNT_WIDTH  packets forwarded per source.
REQ-015 SHALL have port busy  out  1  high while a packet is granted.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT0, GRANT1; grant state register drives a combinational mux (zero-cycle data latency while granted).
REQ-017 In IDLE, SHALL hold s0/s1 tready and m_axis_tvalid low.
REQ-018 In IDLE, SHALL sample ctrl_mode and channel_up; grant issued only if channel_up=1 and an eligible source has tvalid=1; transition next cycle.
REQ-019 Eligibility: mode 00 source0 only; 01 source1 only; 11 source0 when valid, else source1; 10 alternate, preferring the source not granted last when both valid.
REQ-020 Round-robin last-grant register SHALL reset to source1 (first tie goes to source0) and update on every grant.
REQ-021 In GRANTx, m_axis_tvalid/tdata/tlast SHALL equal sx signals, sx_tready = m_axis_tready, other source tready = 0.
REQ-022 GRANTx SHALL return to IDLE on the cycle after a beat with sx_tvalid & m_axis_tready & sx_tlast; minimum one idle bubble between packets.
REQ-023 ctrl_mode changes and channel_up deassertion SHALL NOT abort a granted packet; they take effect at the next IDLE decision.
REQ-024 pkt_cntx SHALL increment on each accepted tlast beat of source x, saturating at all-ones.
REQ-025 cnt_clr SHALL zero both counters next cycle; clear wins over a simultaneous increment.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Output signals SHALL be glitch-safe with respect to AXI rules: m_axis_tvalid, once high, stays high until accepted (inherited from source compliance).

Reset
REQ-028 On m_axis_aresetn=0, SHALL asynchronously force state IDLE, last-grant=source1, counters 0, all tready/tvalid/tlast/busy 0, m_axis_tdata 0.
REQ-029 Reset mid-packet SHALL drop the grant immediately; the partial packet is not counted.

Structure
REQ-030 State encoding and ctrl_mode constants (MODE_HOST, MODE_LOOP, MODE_RR, MODE_PRIO) SHALL live in a shared package used by the register wrapper.
REQ-031 Counters SHALL be one sub-module, sat_pkt_cnt, instantiated twice.

Verification
REQ-032 Mode 00, channel_up=1, s0 sends 3-beat packet 0xA1,0xA2,0xA3 -> identical beats on m_axis, pkt_cnt0=1, s1_tready stays 0.
REQ-033 Mode 10, both sources continuously valid with 2-beat packets -> grant order 0,1,0,1, pkt_cnt0=pkt_cnt1=2 after 4 packets.
REQ-034 Mode 11, both valid -> source0 granted every time; source1 granted only when s0_tvalid=0 in IDLE.
REQ-035 channel_up=0 with s0 valid -> no grant; channel_up drops during GRANT0 with m_axis_tready toggling -> packet completes, then IDLE holds.
REQ-036 Preload pkt_cnt0 to 0xFFFF via 65535 packets (or forced) -> stays 0xFFFF; cnt_clr coincident with tlast -> 0.
REQ-037 Assert m_axis_aresetn=0 mid-packet -> all outputs 0 asynchronously, counters 0, first post-reset tie grants source0.
